// File: rtl/cordic_log_pkg.sv
// Shared constants, angle table, FSM state type and repeat schedule for the
// hyperbolic-CORDIC natural-log engine (Q7.25 fixed point).
package cordic_log_pkg;

    localparam int unsigned Q_W       = 32;
    localparam int unsigned FRAC_BITS = 25;
    localparam int unsigned IDX_W     = 5;

    localparam logic [Q_W-1:0] LN2_Q25 = 32'h0162_E430;

    // atanh(2^-i) in Q7.25; entry 0 is unused.
    localparam logic [Q_W-1:0] ATANH_Q25 [32] = '{
        32'h0000_0000, 32'h0119_3EA8, 32'h0082_C578, 32'h0040_5624,
        32'h0020_0AB1, 32'h0010_0156, 32'h0008_002B, 32'h0004_0005,
        32'h0002_0001, 32'h0001_0000, 32'h0000_8000, 32'h0000_4000,
        32'h0000_2000, 32'h0000_1000, 32'h0000_0800, 32'h0000_0400,
        32'h0000_0200, 32'h0000_0100, 32'h0000_0080, 32'h0000_0040,
        32'h0000_0020, 32'h0000_0010, 32'h0000_0008, 32'h0000_0004,
        32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000,
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SCALE = 2'd2
    } state_t;

    // Step -> shift index: 1,2,3,4,4,5,...,13,13,14,... (4 and 13 repeated).
    function automatic logic [IDX_W-1:0] shift_idx(input logic [IDX_W-1:0] step);
        logic [IDX_W-1:0] idx;
        idx = step + IDX_W'(1);
        if (step >= IDX_W'(4))  idx = idx - IDX_W'(1);
        if (step >= IDX_W'(14)) idx = idx - IDX_W'(1);
        return idx;
    endfunction

endpackage

// File: rtl/cordic_atanh_rom.sv
// Combinational atanh(2^-i) lookup for the CORDIC micro-rotations.
module cordic_atanh_rom
    import cordic_log_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [Q_W-1:0]   atanh_c
);

    always_comb atanh_c = ATANH_Q25[idx];

endmodule

// File: rtl/cordic_log_core.sv
// Iterative hyperbolic-CORDIC ln() engine, one micro-rotation per clock.
// CORDIC_EXP_CORR_EN adds exponent*ln2 with saturation; otherwise ln(1+m) only.
module cordic_log_core
    import cordic_log_pkg::*;
#(
    parameter int unsigned ITER = 16,
    parameter int unsigned W    = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [7:0]   exponent,
    input  logic         valid,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] log_out
);

    localparam int unsigned N = ITER + ((ITER >= 4) ? 1 : 0) + ((ITER >= 13) ? 1 : 0);
    localparam logic [IDX_W-1:0] LAST_STEP = IDX_W'(N - 1);

    state_t              state, state_nx;
    logic signed [W-1:0] xr, yr, zr;
    logic [IDX_W-1:0]    step, idx_c;
    logic [Q_W-1:0]      atanh_c;
    logic signed [W-1:0] xs_c, ys_c, at_c;
    logic [W-1:0]        scaled_c;

    assign idx_c = shift_idx(step);
    assign xs_c  = xr >>> idx_c;
    assign ys_c  = yr >>> idx_c;
    assign at_c  = W'(atanh_c);

    cordic_atanh_rom u_rom (
        .idx     (idx_c),
        .atanh_c (atanh_c)
    );

`ifdef CORDIC_EXP_CORR_EN
    localparam int unsigned EW = 40;
    localparam logic signed [EW-1:0] SAT_HI = $signed(EW'(1) << (W - 1));
    localparam logic signed [EW-1:0] SAT_LO = -SAT_HI;

    logic [7:0]           exp_r;
    logic signed [EW-1:0] z2_c, prod_c, res_c;

    // 2*z +/- |e|*ln2 at extended width, clamped to the Q7.25 range.
    always_comb begin
        z2_c     = {{(EW - W){zr[W-1]}}, zr};
        z2_c     = z2_c <<< 1;
        prod_c   = EW'(exp_r[6:0]) * EW'(LN2_Q25);
        res_c    = exp_r[7] ? (z2_c - prod_c) : (z2_c + prod_c);
        scaled_c = res_c[W-1:0];
        if (res_c >= SAT_HI)
            scaled_c = {1'b0, {(W - 1){1'b1}}};
        else if (res_c <= SAT_LO)
            scaled_c = {1'b1, {(W - 1){1'b0}}};
    end
`else
    logic unused_exponent;
    assign unused_exponent = ^exponent;
    assign scaled_c        = W'(zr <<< 1);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (valid) state_nx = RUN;
            RUN:     if (step == LAST_STEP) state_nx = SCALE;
            SCALE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: capture, micro-rotate (pre-edge values on both sides), scale.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xr      <= '0;
            yr      <= '0;
            zr      <= '0;
            step    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            log_out <= '0;
`ifdef CORDIC_EXP_CORR_EN
            exp_r   <= '0;
`endif
        end else begin
            busy <= (state_nx != IDLE);
            done <= (state == SCALE);
            case (state)
                IDLE: if (valid) begin
                    xr    <= $signed(x);
                    yr    <= $signed(y);
                    zr    <= '0;
                    step  <= '0;
`ifdef CORDIC_EXP_CORR_EN
                    exp_r <= exponent;
`endif
                end
                RUN: begin
                    if (!yr[W-1]) begin
                        xr <= xr - ys_c;
                        yr <= yr - xs_c;
                        zr <= zr + at_c;
                    end else begin
                        xr <= xr + ys_c;
                        yr <= yr + xs_c;
                        zr <= zr - at_c;
                    end
                    step <= step + IDX_W'(1);
                end
                SCALE: log_out <= scaled_c;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_log_core.sv
// Self-checking bench for cordic_log_core: fixed vectors, multi-cycle corner
// sequences and randomized mantissa/exponent against a real-arithmetic ln model.
module tb_cordic_log_core;

`ifdef CORDIC_EXP_CORR_EN
    localparam bit CORR = 1'b1;
`else
    localparam bit CORR = 1'b0;
`endif

    localparam longint TOL = 1536;
    localparam int     LAT = 19;

    logic        clk;
    logic        reset;
    logic [31:0] x, y;
    logic [7:0]  exponent;
    logic        valid;
    logic        busy, done;
    logic [31:0] log_out;

    int n_vec = 0;
    int n_err = 0;

    cordic_log_core dut (
        .clk      (clk),
        .reset    (reset),
        .x        (x),
        .y        (y),
        .exponent (exponent),
        .valid    (valid),
        .busy     (busy),
        .done     (done),
        .log_out  (log_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] xi;
        logic [31:0] yi;
        logic [7:0]  ei;
        longint      exp_on;
        longint      exp_off;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input longint act, input longint expv, input longint tol);
        longint d;
        n_vec++;
        d = act - expv;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, expv, tol);
        end
    endtask

    // ln(1+m) from x/y, plus signed exponent * ln2, saturated to Q7.25.
    function automatic longint model(input logic [31:0] xi, input logic [31:0] yi, input logic [7:0] ei);
        real num, den, v;
        int  e;
        num = xi + yi;
        den = xi - yi;
        v   = $ln(num / den);
        e   = int'(ei[6:0]);
        if (ei[7]) e = -e;
        if (CORR) v = v + e * $ln(2.0);
        v = v * 33554432.0;
        if (v >= 2147483648.0)  return 64'sd2147483647;
        if (v <= -2147483648.0) return -64'sd2147483648;
        return longint'(v);
    endfunction

    task automatic start(input logic [31:0] xi, input logic [31:0] yi, input logic [7:0] ei);
        x = xi; y = yi; exponent = ei; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    function automatic longint sres();
        return longint'($signed(log_out));
    endfunction

    initial begin
        int          lat, bcnt, ndone;
        logic [31:0] f;
        logic [7:0]  ei;
        longint      expv;

        vecs[0] = '{32'h0500_0000, 32'h0100_0000, 8'h80, 64'sd13605148,    64'sd13605148};
        vecs[1] = '{32'h0500_0000, 32'h0100_0000, 8'h01, 64'sd36863311,    64'sd13605148};
        vecs[2] = '{32'h0500_0000, 32'h0100_0000, 8'h81, -64'sd9653010,    64'sd13605148};
        vecs[3] = '{32'h0500_0000, 32'h0100_0000, 8'h64, 64'sd2147483647,  64'sd13605148};
        vecs[4] = '{32'h0500_0000, 32'h0100_0000, 8'hE4, -64'sd2147483648, 64'sd13605148};
        vecs[5] = '{32'h0480_0000, 32'h0080_0000, 8'h00, 64'sd7487455,     64'sd7487455};
        vecs[6] = '{32'h05E0_0000, 32'h01E0_0000, 8'h81, -64'sd1065308,    64'sd22192850};

        reset = 1'b0; valid = 1'b0; x = '0; y = '0; exponent = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", longint'(busy), 0, 0);
        check("reset_done", longint'(done), 0, 0);
        check("reset_log",  sres(), 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Fixed vectors: latency, busy length, value, one-cycle done
        for (int i = 0; i < 7; i++) begin
            start(vecs[i].xi, vecs[i].yi, vecs[i].ei);
            wait_done(lat, bcnt);
            check($sformatf("vec%0d_lat", i),  longint'(lat),  LAT, 0);
            check($sformatf("vec%0d_busy", i), longint'(bcnt), LAT, 0);
            check($sformatf("vec%0d_val", i),  sres(), CORR ? vecs[i].exp_on : vecs[i].exp_off, TOL);
            @(posedge clk); #1;
            check($sformatf("vec%0d_pulse", i), longint'(done), 0, 0);
        end

        // valid during RUN is dropped
        start(32'h0500_0000, 32'h0100_0000, 8'h01);
        lat = 0;
        while (!done && lat < 60) begin
            if (lat == 5) begin
                x = 32'h0480_0000; y = 32'h0080_0000; exponent = 8'h81; valid = 1'b1;
            end
            @(posedge clk); #1;
            valid = 1'b0;
            lat++;
        end
        check("drop_lat", longint'(lat), LAT, 0);
        check("drop_val", sres(), CORR ? 64'sd36863311 : 64'sd13605148, TOL);
        ndone = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check("drop_no_second", longint'(ndone), 0, 0);

        // valid in the done cycle starts a new computation
        start(32'h0500_0000, 32'h0100_0000, 8'h01);
        wait_done(lat, bcnt);
        check("b2b_first_lat", longint'(lat), LAT, 0);
        start(32'h0500_0000, 32'h0100_0000, 8'h81);
        check("b2b_busy", longint'(busy), 1, 0);
        wait_done(lat, bcnt);
        check("b2b_second_lat", longint'(lat), LAT, 0);
        check("b2b_second_val", sres(), CORR ? -64'sd9653010 : 64'sd13605148, TOL);

        // reset mid-RUN aborts with no done
        start(32'h0500_0000, 32'h0100_0000, 8'h01);
        repeat (10) begin @(posedge clk); #1; end
        reset = 1'b0;
        #1;
        check("abort_busy", longint'(busy), 0, 0);
        check("abort_done", longint'(done), 0, 0);
        check("abort_log",  sres(), 0, 0);
        @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check("abort_no_done", longint'(ndone), 0, 0);
        start(32'h0500_0000, 32'h0100_0000, 8'h80);
        wait_done(lat, bcnt);
        check("abort_fresh_lat", longint'(lat), LAT, 0);
        check("abort_fresh_val", sres(), 64'sd13605148, TOL);

        // Randomized mantissa in (0,1) and sign-magnitude exponent
        for (int r = 0; r < 24; r++) begin
            f  = $urandom_range(32'h01FF_FFFF, 1);
            ei[7]   = 1'($urandom_range(1, 0));
            ei[6:0] = (r % 4 == 0) ? 7'($urandom_range(127, 0)) : 7'($urandom_range(40, 0));
            expv = model(32'h0400_0000 + f, f, ei);
            start(32'h0400_0000 + f, f, ei);
            wait_done(lat, bcnt);
            check($sformatf("rnd%0d_lat", r), longint'(lat), LAT, 0);
            check($sformatf("rnd%0d_val f=%h e=%h", r, f, ei), sres(), expv, TOL);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
